screen_compositor: RTL and testbench
====================================

# screen_compositor

Downstream stage of the game-screen renderers. It scans the 96x64 OLED raster on pixel requests and drives the `x`/`y` coordinates into the screen modules. It takes the current-screen and next-screen RGB565 colours back and composites them, with a left-to-right column wipe during a screen transition. It returns the chosen colour to the OLED driver with a one-cycle request/valid handshake and owns the active-screen selection seen by the upstream screen mux.

## Interface
Parameters:
- `NUM_SCREENS`, default 10: number of selectable game screens; indices 0..NUM_SCREENS-1.
- `WIPE_STEP`, default 4: columns the wipe boundary advances per frame; legal range 1..96.
- `SEL_W`, default 4: width of screen-select outputs; must satisfy 2^SEL_W >= NUM_SCREENS.

Ports:
- `clk` in 1: system clock; the block's only clock.
- `reset` in 1: asynchronous, active-high reset.
- `frame_begin` in 1: one-cycle pulse from the OLED driver at the start of each frame.
- `pix_req` in 1: one-cycle pulse; the driver requests the next raster pixel.
- `advance` in 1: debounced one-cycle pulse; request a transition to the next screen.
- `cur_data` in 16: RGB565 colour of the current screen at (`x`,`y`); combinational from the screen mux.
- `nxt_data` in 16: RGB565 colour of the next screen at (`x`,`y`); combinational from the screen mux.
- `x` out 7: registered column, 0..95.
- `y` out 6: registered row, 0..63.
- `cur_sel` out SEL_W: index of the current screen.
- `nxt_sel` out SEL_W: index of the next screen; equals `cur_sel` when IDLE.
- `oled_data` out 16: registered composited colour.
- `pix_valid` out 1: one-cycle pulse; `oled_data` holds the answer to the previous `pix_req`.
- `busy` out 1: high while a transition is in progress.
- `frame_cnt` out 8: frames since reset; wraps 255 -> 0.

## Operation
- Raster counter:
  - `frame_begin` sets `x`=0, `y`=0.
  - Each `pix_req` that is served advances the counter as follows:
    - `x`+1, or `x`=0 and `y`+1 when `x`=95.
    - At `x`=95, `y`=63 the counter wraps to (0,0).
- Compositing, evaluated when a `pix_req` is served:
  - If the state is WIPE and `x` < `wipe_col`, the colour is `nxt_data`.
  - Otherwise the colour is `cur_data`.
  - The colour is latched into `oled_data` using the `x`/`y` values held before the increment.
- FSM states: IDLE, ARM, WIPE.
  - IDLE, `advance`=1 -> ARM:
    - `nxt_sel` = `cur_sel`+1, wrapping NUM_SCREENS-1 -> 0.
    - `wipe_col` = 0.
  - ARM, `frame_begin` -> WIPE. This starts the wipe on a frame boundary.
  - WIPE, `frame_begin`:
    - `wipe_col` = min(`wipe_col`+WIPE_STEP, 96).
    - If `wipe_col` was already 96 before this `frame_begin`, instead set `cur_sel` = `nxt_sel` and go to IDLE.
  - `advance` in ARM or WIPE is ignored and not queued.
- `wipe_col` is internal, 7 bits (0..96). It changes only on `frame_begin`, so no frame shows a torn boundary.
- `busy` is high in ARM and WIPE.
- `frame_cnt` increments on every `frame_begin`.

## Timing
- Reset values:
  - `x`=0, `y`=0, `oled_data`=16'h0000, `pix_valid`=0.
  - `cur_sel`=0, `nxt_sel`=0, `busy`=0, `frame_cnt`=0.
  - State IDLE, `wipe_col`=0.
- Pixel latency: `pix_req` in cycle N -> `oled_data` updated and `pix_valid`=1 in cycle N+1. `x`/`y` show the next coordinate in cycle N+1.
- `cur_data`/`nxt_data` must settle within one cycle of an `x`/`y`/`sel` change. `pix_req` pulses are therefore at least 2 cycles apart; back-to-back `pix_req` is unsupported.
- `frame_begin` and `pix_req` in the same cycle:
  - `frame_begin` has priority.
  - The request is dropped and `pix_valid` stays 0.
  - `x`/`y` go to 0.
- `frame_begin` and `advance` in the same cycle while IDLE: the FSM enters ARM. The wipe starts at the following `frame_begin`.
- `cur_sel`/`nxt_sel` change only on `frame_begin` (WIPE exit) or on `advance` (IDLE->ARM). `nxt_sel` is not used for compositing until WIPE.
- Transition length with WIPE_STEP=4:
  - 24 frames raise `wipe_col` to 96.
  - One further frame is displayed fully as the next screen.
  - IDLE is reached at the 26th `frame_begin` after ARM.
- `reset` asserted mid-transition: outputs immediately return to their reset values; the transition is abandoned.

## Structure
- Shared package `oled_pkg`:
  - `OLED_W`=96, `OLED_H`=64, `PIX_COUNT`=6144.
  - RGB565 colour constants.
  - Compositor state enum {IDLE, ARM, WIPE}.
- Sub-module `raster_counter`: `x`/`y` counter with `frame_begin` clear and request-driven increment. Top level holds the FSM, wipe register, select logic and output mux.

## Test plan
- Reset, then 6144 `pix_req` pulses spaced 2 cycles apart -> `x`/`y` walk (0,0)..(95,63) and wrap to (0,0). `pix_valid` goes high 6144 times.
- IDLE with `cur_data`=16'h07E0 and `nxt_data`=16'hF800 -> every `oled_data`=16'h07E0.
- WIPE_STEP=4, `cur_sel`=0, `advance`, then frames:
  - Third frame after ARM (`wipe_col`=8) -> pixels with `x`<8 carry `nxt_data`, the rest `cur_data`.
  - `cur_sel` becomes 1 at the 26th `frame_begin`.
- `cur_sel`=NUM_SCREENS-1=9, `advance` -> `nxt_sel`=0; after the transition `cur_sel`=0.
- `advance` pulses during ARM and WIPE -> no extra transition; `busy` falls exactly once.
- `frame_begin` coincident with `pix_req` -> no `pix_valid`, `x`=`y`=0.
- `reset` asserted at `wipe_col`=40 -> `busy`=0, `cur_sel`=0, `frame_cnt`=0 immediately.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants, colours and types for the OLED compositing path.
package oled_pkg;

  localparam int unsigned OLED_W    = 96;
  localparam int unsigned OLED_H    = 64;
  localparam int unsigned PIX_COUNT = OLED_W * OLED_H;

  // RGB565 colour constants
  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_RED   = 16'hF800;
  localparam logic [15:0] COLOR_GREEN = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE  = 16'h001F;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StWipe
  } comp_state_e;

  // Advance the wipe boundary by one step, saturating at the screen width.
  function automatic logic [6:0] wipe_next(input logic [6:0] col, input int unsigned step);
    logic [7:0] sum;
    sum = {1'b0, col} + 8'(step);
    if (sum >= 8'(OLED_W)) begin
      return 7'(OLED_W);
    end
    return sum[6:0];
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster scan counter: clears on frame start, steps once per served pixel request.
module raster_counter
  import oled_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_begin,
  input  logic       step,
  output logic [6:0] x,
  output logic [5:0] y
);

  // Column/row register; frame_begin takes priority over a step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (frame_begin) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x == 7'(OLED_W - 1)) begin
        x <= '0;
        y <= (y == 6'(OLED_H - 1)) ? 6'd0 : y + 6'd1;
      end else begin
        x <= x + 7'd1;
      end
    end
  end

endmodule

// File: rtl/screen_compositor.sv
// Composites current/next screen colours with a left-to-right column wipe
// and owns the active screen selection.
module screen_compositor
  import oled_pkg::*;
#(
  parameter int unsigned NUM_SCREENS = 10,
  parameter int unsigned WIPE_STEP   = 4,
  parameter int unsigned SEL_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_begin,
  input  logic             pix_req,
  input  logic             advance,
  input  logic [15:0]      cur_data,
  input  logic [15:0]      nxt_data,
  output logic [6:0]       x,
  output logic [5:0]       y,
  output logic [SEL_W-1:0] cur_sel,
  output logic [SEL_W-1:0] nxt_sel,
  output logic [15:0]      oled_data,
  output logic             pix_valid,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  comp_state_e      state_q, state_d;
  logic [6:0]       wipe_col_q, wipe_col_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0] nxt_sel_q, nxt_sel_d;
  logic [SEL_W-1:0] sel_inc;
  logic             serve;
  logic [15:0]      pix_color;

  // A request coinciding with frame_begin is dropped.
  assign serve = pix_req & ~frame_begin;

  raster_counter u_raster (
    .clk         (clk),
    .reset       (reset),
    .frame_begin (frame_begin),
    .step        (serve),
    .x           (x),
    .y           (y)
  );

  // Next screen index, wrapping at the last screen.
  always_comb begin
    sel_inc = cur_sel_q + 1'b1;
    if (cur_sel_q == SEL_W'(NUM_SCREENS - 1)) begin
      sel_inc = '0;
    end
  end

  // Transition FSM next-state, wipe boundary and select update.
  always_comb begin
    state_d    = state_q;
    wipe_col_d = wipe_col_q;
    cur_sel_d  = cur_sel_q;
    nxt_sel_d  = nxt_sel_q;
    unique case (state_q)
      StIdle: begin
        if (advance) begin
          state_d    = StArm;
          nxt_sel_d  = sel_inc;
          wipe_col_d = '0;
        end
      end
      StArm: begin
        if (frame_begin) begin
          state_d = StWipe;
        end
      end
      StWipe: begin
        if (frame_begin) begin
          // One full frame of the next screen is shown before handing over.
          if (wipe_col_q == 7'(OLED_W)) begin
            cur_sel_d  = nxt_sel_q;
            state_d    = StIdle;
            wipe_col_d = '0;
          end else begin
            wipe_col_d = wipe_next(wipe_col_q, WIPE_STEP);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM, wipe and select state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wipe_col_q <= '0;
      cur_sel_q  <= '0;
      nxt_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      wipe_col_q <= wipe_col_d;
      cur_sel_q  <= cur_sel_d;
      nxt_sel_q  <= nxt_sel_d;
    end
  end

  // Column left of the wipe boundary shows the incoming screen.
  always_comb begin
    pix_color = cur_data;
    if ((state_q == StWipe) && (x < wipe_col_q)) begin
      pix_color = nxt_data;
    end
  end

  // Pixel output, handshake and frame counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oled_data <= COLOR_BLACK;
      pix_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      pix_valid <= serve;
      if (serve) begin
        oled_data <= pix_color;
      end
      if (frame_begin) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign cur_sel = cur_sel_q;
  assign nxt_sel = nxt_sel_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_screen_compositor.sv
// Scoreboard bench for screen_compositor: stimulus pushes expected colours,
// a monitor pops and compares on every pix_valid.
module tb_screen_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_begin;
  logic        pix_req;
  logic        advance;
  logic [15:0] cur_data;
  logic [15:0] nxt_data;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  cur_sel;
  logic [3:0]  nxt_sel;
  logic [15:0] oled_data;
  logic        pix_valid;
  logic        busy;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int busy_falls = 0;
  logic busy_prev = 1'b0;

  // Bench model state
  int x_m = 0;
  int y_m = 0;
  int fcnt_m = 0;
  bit const_mode = 1'b0;
  bit exp_wiping = 1'b0;
  int exp_wipe = 0;
  logic [15:0] sb_q[$];

  screen_compositor dut (
    .clk         (clk),
    .reset       (reset),
    .frame_begin (frame_begin),
    .pix_req     (pix_req),
    .advance     (advance),
    .cur_data    (cur_data),
    .nxt_data    (nxt_data),
    .x           (x),
    .y           (y),
    .cur_sel     (cur_sel),
    .nxt_sel     (nxt_sel),
    .oled_data   (oled_data),
    .pix_valid   (pix_valid),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // Screen mux emulation: colour encodes coordinate so latency errors show up.
  assign cur_data = const_mode ? 16'h07E0 : {3'b001, y, x};
  assign nxt_data = const_mode ? 16'hF800 : {3'b110, y, x};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_color(input int xc, input int yc);
    logic use_nxt;
    use_nxt = exp_wiping && (xc < exp_wipe);
    if (const_mode) return use_nxt ? 16'hF800 : 16'h07E0;
    return use_nxt ? {3'b110, 6'(yc), 7'(xc)} : {3'b001, 6'(yc), 7'(xc)};
  endfunction

  // Monitor: every pix_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && pix_valid) begin
      valid_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pix_valid: got oled_data 0x%0h expected no pixel", oled_data);
      end else begin
        check("oled_data", 32'(oled_data), 32'(sb_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (busy_prev && !busy) busy_falls++;
    busy_prev = busy;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fb();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    x_m = 0;
    y_m = 0;
    fcnt_m = (fcnt_m + 1) % 256;
  endtask

  task automatic pix();
    sb_q.push_back(exp_color(x_m, y_m));
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    if (x_m == 95) begin
      x_m = 0;
      y_m = (y_m == 63) ? 0 : y_m + 1;
    end else begin
      x_m++;
    end
    check("x", 32'(x), 32'(x_m));
    check("y", 32'(y), 32'(y_m));
    tick();
  endtask

  task automatic pulse_advance();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  task automatic full_transition();
    pulse_advance();
    repeat (26) fb();
  endtask

  initial begin
    reset = 1'b1;
    frame_begin = 1'b0;
    pix_req = 1'b0;
    advance = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_oled_data", 32'(oled_data), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_cur_sel", 32'(cur_sel), 0);
    check("rst_nxt_sel", 32'(nxt_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);

    // Full raster walk with wrap
    fb();
    repeat (6144) pix();
    check("walk_valid_count", 32'(valid_cnt), 6144);
    check("frame_cnt_1", 32'(frame_cnt), 32'(fcnt_m));

    // Idle compositing always shows the current screen
    const_mode = 1'b1;
    repeat (20) pix();
    const_mode = 1'b0;

    // Transition 0 -> 1 with stray advances in ARM and WIPE
    pulse_advance();
    check("arm_busy", 32'(busy), 1);
    check("arm_nxt_sel", 32'(nxt_sel), 1);
    check("arm_cur_sel", 32'(cur_sel), 0);
    pulse_advance();
    check("arm_ignore_nxt_sel", 32'(nxt_sel), 1);
    fb();                       // enter WIPE, boundary 0
    exp_wiping = 1'b1;
    exp_wipe = 0;
    repeat (3) pix();
    pulse_advance();
    check("wipe_ignore_nxt_sel", 32'(nxt_sel), 1);
    fb();                       // boundary 4
    exp_wipe = 4;
    repeat (6) pix();
    fb();                       // boundary 8
    exp_wipe = 8;
    repeat (12) pix();
    repeat (22) fb();           // frames 4..25, boundary saturates at 96
    exp_wipe = 96;
    repeat (100) pix();
    check("wipe96_busy", 32'(busy), 1);
    check("wipe96_cur_sel", 32'(cur_sel), 0);
    fb();                       // 26th frame: hand over
    exp_wiping = 1'b0;
    check("done_cur_sel", 32'(cur_sel), 1);
    check("done_nxt_sel", 32'(nxt_sel), 1);
    check("done_busy", 32'(busy), 0);
    repeat (3) pix();
    repeat (30) fb();
    check("busy_falls_once", 32'(busy_falls), 1);
    check("idle_cur_sel", 32'(cur_sel), 1);
    check("frame_cnt_2", 32'(frame_cnt), 32'(fcnt_m));

    // frame_begin coincident with pix_req drops the request
    repeat (5) pix();
    frame_begin = 1'b1;
    pix_req = 1'b1;
    tick();
    frame_begin = 1'b0;
    pix_req = 1'b0;
    x_m = 0;
    y_m = 0;
    fcnt_m = (fcnt_m + 1) % 256;
    check("coinc_pix_valid", 32'(pix_valid), 0);
    check("coinc_x", 32'(x), 0);
    check("coinc_y", 32'(y), 0);
    tick();

    // Reset in the middle of a wipe at boundary 40
    pulse_advance();
    repeat (11) fb();
    exp_wiping = 1'b1;
    exp_wipe = 40;
    repeat (3) pix();
    check("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cur_sel", 32'(cur_sel), 0);
    check("midrst_nxt_sel", 32'(nxt_sel), 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    check("midrst_x", 32'(x), 0);
    tick();
    reset = 1'b0;
    exp_wiping = 1'b0;
    x_m = 0;
    y_m = 0;
    fcnt_m = 0;
    tick();

    // Selection wrap: nine transitions to screen 9, then one more to 0
    repeat (9) full_transition();
    check("sel9_cur_sel", 32'(cur_sel), 9);
    pulse_advance();
    check("wrap_nxt_sel", 32'(nxt_sel), 0);
    repeat (26) fb();
    check("wrap_cur_sel", 32'(cur_sel), 0);
    check("wrap_busy", 32'(busy), 0);
    check("frame_cnt_wrap", 32'(frame_cnt), 32'(fcnt_m));
    repeat (3) pix();

    repeat (2) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
